// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI NOR-flash responder.
// Holds the FSM state and data-source encodings plus the supported command opcodes.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StCmd    = 3'd1,
    StAddr   = 3'd2,
    StData   = 3'd3,
    StIgnore = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SrcRom = 2'd0,
    SrcId  = 2'd1,
    SrcSr  = 2'd2
  } src_e;

  localparam logic [7:0] CMD_READ = 8'h03;
  localparam logic [7:0] CMD_RDID = 8'h9F;
  localparam logic [7:0] CMD_RDSR = 8'h05;

  // The status register never reports a write in progress.
  localparam logic [7:0] STATUS_REG = 8'h00;

  function automatic logic [7:0] jedec_byte(input logic [23:0] id, input logic [1:0] idx);
    case (idx)
      2'd0:    return id[23:16];
      2'd1:    return id[15:8];
      default: return id[7:0];
    endcase
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer with a history flop for single-cycle edge pulses.
// Edge pulses appear once the synchronized value differs from the previous cycle.
module spi_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_hist;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_hist <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_hist;
  assign o_fall = ~r_sync & r_hist;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash target (mode 0, single-bit) serving READ, RDID and RDSR from a word ROM.
// All SPI pins are oversampled in the system clock domain.
module spi_flash_responder
  import spi_flash_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flash_cs,
  input  logic              i_flash_clk,
  input  logic              i_flash_io0,
  output logic              o_flash_io1,
  output logic              o_flash_io1_oe,
  output logic [ADDR_W-3:0] o_rom_addr,
  input  logic [31:0]       i_rom_data,
  output logic              o_busy
);

  logic w_cs, w_cs_rise, w_cs_fall;
  logic w_sck, w_sck_rise, w_sck_fall;
  logic w_mosi, w_mosi_rise, w_mosi_fall;
  logic w_unused;

  spi_sync u_sync_cs (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_flash_cs),
    .o_sync  (w_cs),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  spi_sync u_sync_sck (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_flash_clk),
    .o_sync  (w_sck),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  spi_sync u_sync_mosi (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_flash_io0),
    .o_sync  (w_mosi),
    .o_rise  (w_mosi_rise),
    .o_fall  (w_mosi_fall)
  );

  assign w_unused = ^{w_cs_fall, w_sck, w_mosi_rise, w_mosi_fall};

  state_e            r_state,   w_state_nxt;
  src_e              r_src,     w_src_nxt;
  logic [4:0]        r_bit_cnt, w_cnt_nxt;
  logic [22:0]       r_shift,   w_shift_nxt;
  logic [ADDR_W-1:0] r_addr,    w_addr_nxt;
  logic [1:0]        r_id_idx,  w_idx_nxt;
  logic              r_io1,     w_io1_nxt;
  logic              r_oe,      w_oe_nxt;
  logic              r_busy,    w_busy_nxt;
  logic              r_armed,   w_armed_nxt;
  logic [7:0]        w_tx_byte;

  always_comb begin
    unique case (r_src)
      SrcId:   w_tx_byte = jedec_byte(JEDEC_ID, r_id_idx);
      SrcSr:   w_tx_byte = STATUS_REG;
      default: w_tx_byte = i_rom_data[{r_addr[1:0], 3'b000} +: 8];
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_cnt_nxt   = r_bit_cnt;
    w_shift_nxt = r_shift;
    w_addr_nxt  = r_addr;
    w_idx_nxt   = r_id_idx;
    w_io1_nxt   = r_io1;
    w_oe_nxt    = r_oe;
    w_busy_nxt  = r_busy;
    // A CS already low when reset releases must be seen high before it can select us.
    w_armed_nxt = r_armed | w_cs_rise;

    if (r_state != StIdle && w_cs) begin
      // Deselect wins over any SCK edge in the same cycle; the partial byte is dropped.
      w_state_nxt = StIdle;
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
      w_io1_nxt   = 1'b0;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!w_cs && r_armed) begin
            w_state_nxt = StCmd;
            w_busy_nxt  = 1'b1;
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
          end
        end
        StCmd: begin
          if (w_sck_rise) begin
            w_shift_nxt = {r_shift[21:0], w_mosi};
            w_cnt_nxt   = r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              w_cnt_nxt = '0;
              w_idx_nxt = '0;
              case ({r_shift[6:0], w_mosi})
                CMD_READ: w_state_nxt = StAddr;
                CMD_RDID: begin
                  w_state_nxt = StData;
                  w_src_nxt   = SrcId;
                end
                CMD_RDSR: begin
                  w_state_nxt = StData;
                  w_src_nxt   = SrcSr;
                end
                default:  w_state_nxt = StIgnore;
              endcase
            end
          end
        end
        StAddr: begin
          if (w_sck_rise) begin
            w_shift_nxt = {r_shift[21:0], w_mosi};
            w_cnt_nxt   = r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd23) begin
              // Upper address bits beyond ADDR_W are discarded by the truncating cast.
              w_addr_nxt  = ADDR_W'({r_shift, w_mosi});
              w_cnt_nxt   = '0;
              w_state_nxt = StData;
              w_src_nxt   = SrcRom;
            end
          end
        end
        StData: begin
          if (w_sck_fall) begin
            w_io1_nxt = w_tx_byte[3'd7 - r_bit_cnt[2:0]];
            w_oe_nxt  = 1'b1;
            w_cnt_nxt = r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'd7) begin
              w_cnt_nxt = '0;
              if (r_src == SrcRom) begin
                w_addr_nxt = r_addr + ADDR_W'(1);
              end
              if (r_src == SrcId) begin
                w_idx_nxt = (r_id_idx == 2'd2) ? 2'd0 : r_id_idx + 2'd1;
              end
            end
          end
        end
        StIgnore: ;
        default:  w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_src     <= SrcRom;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_id_idx  <= '0;
      r_io1     <= 1'b0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
      r_armed   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_src     <= w_src_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_addr    <= w_addr_nxt;
      r_id_idx  <= w_idx_nxt;
      r_io1     <= w_io1_nxt;
      r_oe      <= w_oe_nxt;
      r_busy    <= w_busy_nxt;
      r_armed   <= w_armed_nxt;
    end
  end

  assign o_flash_io1    = r_io1;
  assign o_flash_io1_oe = r_oe;
  assign o_rom_addr     = r_addr[ADDR_W-1:2];
  assign o_busy         = r_busy;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized scoreboard bench for spi_flash_responder: a monitor assembles MISO bytes
// on SCK rising edges and compares them against bytes queued by the stimulus.
module tb_spi_flash_responder;

  localparam int          HALF = 6;
  localparam logic [23:0] ID   = 24'hEF4016;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs    = 1'b1;
  logic        sck   = 1'b0;
  logic        mosi  = 1'b0;
  logic        io1;
  logic        io1_oe;
  logic        busy;
  logic [13:0] rom_addr;
  logic [31:0] rom_data;
  logic [31:0] mem [0:16383];

  int n_tests  = 0;
  int n_fail   = 0;
  int oe_count = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  assign rom_data = mem[rom_addr];

  spi_flash_responder dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flash_cs     (cs),
    .i_flash_clk    (sck),
    .i_flash_io0    (mosi),
    .o_flash_io1    (io1),
    .o_flash_io1_oe (io1_oe),
    .o_rom_addr     (rom_addr),
    .i_rom_data     (rom_data),
    .o_busy         (busy)
  );

  always @(posedge clk) if (io1_oe) oe_count++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a controller samples MISO on the SCK rising edge.
  int         mon_cnt = 0;
  logic [7:0] mon_sr  = 8'h00;
  always @(posedge sck or posedge cs or negedge rst_n) begin
    if (!rst_n || cs) begin
      mon_cnt = 0;
    end else if (io1_oe) begin
      mon_sr = {mon_sr[6:0], io1};
      mon_cnt++;
      if (mon_cnt == 8) begin
        mon_cnt = 0;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL miso_unexpected: got byte %02h, expected no byte", mon_sr);
        end else begin
          check("miso_byte", 32'(mon_sr), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  function automatic logic [7:0] exp_byte(input logic [7:0] cmd, input int unsigned addr,
                                          input int unsigned k);
    int unsigned a;
    logic [31:0] w;
    logic [23:0] t;
    case (cmd)
      8'h03: begin
        a = (addr + k) % 65536;
        w = mem[a / 4];
        return w[8 * (a % 4) +: 8];
      end
      8'h9F: begin
        t = ID >> (8 * (2 - (k % 3)));
        return t[7:0];
      end
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sck_bit(input logic b);
    mosi = b;
    tick(HALF);
    sck = 1'b1;
    tick(HALF);
    sck = 1'b0;
  endtask

  task automatic send(input logic [31:0] v, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) sck_bit(v[i]);
  endtask

  task automatic run_txn(input logic [7:0] cmd, input logic [23:0] addr, input int nbits);
    int   nbytes;
    int   oe0;
    logic known;
    nbytes = nbits / 8;
    known  = (cmd == 8'h03) || (cmd == 8'h9F) || (cmd == 8'h05);
    if (known) for (int k = 0; k < nbytes; k++) exp_q.push_back(exp_byte(cmd, addr, k));
    oe0 = oe_count;
    cs  = 1'b0;
    tick(HALF);
    check("busy_selected", 32'(busy), 32'd1);
    send(32'(cmd), 8);
    if (cmd == 8'h03) begin
      send(32'(addr), 24);
      check("rom_addr_start", 32'(rom_addr), (32'(addr) % 65536) / 4);
    end
    for (int i = 0; i < nbits; i++) sck_bit(1'($urandom));
    tick(HALF);
    cs = 1'b1;
    tick(4);
    check("oe_after_cs", 32'(io1_oe), 32'd0);
    check("busy_after_cs", 32'(busy), 32'd0);
    check("io1_after_cs", 32'(io1), 32'd0);
    if (cmd == 8'h03)
      check("rom_addr_end", 32'(rom_addr), ((32'(addr) + 32'(nbytes)) % 65536) / 4);
    if (!known) check("oe_ignore", 32'(oe_count - oe0), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    tick(HALF);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int oe0;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;
    mem[1] = 32'h44332211;
    mem[2] = 32'h88776655;

    // Reset held: CS and SCK activity must not wake the block.
    for (int i = 0; i < 20; i++) begin
      cs = 1'(i % 2);
      sck_bit(1'($urandom));
      check("reset_quiet", 32'({io1, io1_oe, busy, rom_addr}), 32'd0);
    end
    cs = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(HALF);

    run_txn(8'h03, 24'h000004, 64);
    run_txn(8'h03, 24'h00FFFE, 32);
    run_txn(8'h9F, 24'h0, 56);
    run_txn(8'h05, 24'h0, 24);
    run_txn(8'hAB, 24'h0, 16);
    run_txn(8'h03, 24'h000010, 16);
    run_txn(8'h03, 24'h000000, 11);
    run_txn(8'h03, 24'h000000, 8);

    for (int t = 0; t < 15; t++) begin
      logic [7:0] c;
      case ($urandom_range(0, 3))
        0:       c = 8'h03;
        1:       c = 8'h9F;
        2:       c = 8'h05;
        default: c = 8'($urandom);
      endcase
      run_txn(c, 24'($urandom), 8 * int'($urandom_range(1, 4)) + int'($urandom_range(0, 7)));
    end

    // Reset mid-transaction, then release it with CS still low.
    exp_q.push_back(exp_byte(8'h03, 32'h100, 0));
    cs = 1'b0;
    tick(HALF);
    send(32'h03, 8);
    send(32'h000100, 24);
    send(32'h3FF, 10);
    rst_n = 1'b0;
    #1;
    check("reset_async", 32'({io1, io1_oe, busy, rom_addr}), 32'd0);
    check("reset_queue", 32'(exp_q.size()), 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(HALF);
    oe0 = oe_count;
    send(32'h9F, 8);
    send(32'h0, 16);
    check("cs_low_release_busy", 32'(busy), 32'd0);
    check("cs_low_release_oe", 32'(oe_count - oe0), 32'd0);
    cs = 1'b1;
    tick(HALF);
    run_txn(8'h9F, 24'h0, 24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
